// File: rtl/huff_pkg.sv
// rtl/huff_pkg.sv - shared Huffman encoder/packer constants and state type
package huff_pkg;

    localparam int MAX_CHAR_COUNT = 3;
    localparam int ACC_W          = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } huff_state_t;

endpackage

// File: rtl/huff_bit_packer_if.sv
// rtl/huff_bit_packer_if.sv - symbol-in / byte-out stream bundle for the bit packer
interface huff_bit_packer_if;

    logic       sym_valid;
    logic       sym_ready;
    logic [7:0] sym_char;
    logic       sym_last;

    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       out_last;

    modport master (
        output sym_valid, sym_char, sym_last, out_ready,
        input  sym_ready, out_valid, out_byte, out_last
    );

    modport slave (
        input  sym_valid, sym_char, sym_last, out_ready,
        output sym_ready, out_valid, out_byte, out_last
    );

endinterface

// File: rtl/huff_code_lookup.sv
// rtl/huff_code_lookup.sv - combinational code-table search, lowest matching index wins
module huff_code_lookup #(
    parameter  int MAX_CHAR_COUNT = huff_pkg::MAX_CHAR_COUNT,
    localparam int IDX_W = (MAX_CHAR_COUNT > 1) ? $clog2(MAX_CHAR_COUNT) : 1,
    localparam int LEN_W = $clog2(MAX_CHAR_COUNT + 1)
) (
    input  logic [MAX_CHAR_COUNT-1:0][7:0]                table_char,
    input  logic [MAX_CHAR_COUNT-1:0][MAX_CHAR_COUNT-1:0] table_value,
    input  logic [MAX_CHAR_COUNT-1:0][MAX_CHAR_COUNT-1:0] table_mask,
    input  logic [7:0]                                    sym_char,
    output logic                                          match,
    output logic [IDX_W-1:0]                              idx,
    output logic [LEN_W-1:0]                              len,
    output logic [MAX_CHAR_COUNT-1:0]                     value
);

    logic [MAX_CHAR_COUNT-1:0] sel_mask;

    always_comb begin
        match    = 1'b0;
        idx      = '0;
        sel_mask = '0;
        value    = '0;
        // Descending scan so the lowest matching index is the one left standing.
        for (int i = MAX_CHAR_COUNT - 1; i >= 0; i--) begin
            if (table_char[i] == sym_char) begin
                match    = 1'b1;
                idx      = IDX_W'(i);
                sel_mask = table_mask[i];
                value    = table_value[i] & table_mask[i];
            end
        end
        len = '0;
        for (int j = 0; j < MAX_CHAR_COUNT; j++) begin
            len = len + LEN_W'(sel_mask[j]);
        end
    end

endmodule

// File: rtl/huff_bit_packer.sv
// rtl/huff_bit_packer.sv - packs variable-length Huffman codes MSB-first into a byte stream
module huff_bit_packer #(
    parameter  int MAX_CHAR_COUNT = huff_pkg::MAX_CHAR_COUNT,
    parameter  int ACC_W          = huff_pkg::ACC_W,
    localparam int FILL_W = $clog2(ACC_W + 1),
    localparam int IDX_W  = (MAX_CHAR_COUNT > 1) ? $clog2(MAX_CHAR_COUNT) : 1,
    localparam int LEN_W  = $clog2(MAX_CHAR_COUNT + 1)
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          code_load,
    input  logic [MAX_CHAR_COUNT-1:0][7:0]                table_char,
    input  logic [MAX_CHAR_COUNT-1:0][MAX_CHAR_COUNT-1:0] table_value,
    input  logic [MAX_CHAR_COUNT-1:0][MAX_CHAR_COUNT-1:0] table_mask,
    huff_bit_packer_if.slave                              bus,
    output logic                                          err_unknown
);

    import huff_pkg::*;

    localparam logic [FILL_W-1:0] READY_MAX = FILL_W'(ACC_W - MAX_CHAR_COUNT);
    localparam logic [FILL_W-1:0] BYTE_BITS = FILL_W'(8);
    localparam logic [FILL_W-1:0] FULL_W    = FILL_W'(ACC_W);

    huff_state_t state, state_n;

    logic [MAX_CHAR_COUNT-1:0][7:0]                tbl_char;
    logic [MAX_CHAR_COUNT-1:0][MAX_CHAR_COUNT-1:0] tbl_value;
    logic [MAX_CHAR_COUNT-1:0][MAX_CHAR_COUNT-1:0] tbl_mask;

    logic [ACC_W-1:0]  acc, acc_n;
    logic [FILL_W-1:0] fill, fill_n;
    logic              out_valid_n, out_last_n, err_n;
    logic [7:0]        out_byte_n;

    logic                      hit;
    logic [IDX_W-1:0]          hit_idx_unused;
    logic [LEN_W-1:0]          hit_len;
    logic [MAX_CHAR_COUNT-1:0] hit_value;
    logic                      accept, out_free, load_ok;

    huff_code_lookup #(.MAX_CHAR_COUNT(MAX_CHAR_COUNT)) u_lookup (
        .table_char  (tbl_char),
        .table_value (tbl_value),
        .table_mask  (tbl_mask),
        .sym_char    (bus.sym_char),
        .match       (hit),
        .idx         (hit_idx_unused),
        .len         (hit_len),
        .value       (hit_value)
    );

    assign bus.sym_ready = (state == ST_RUN) && (fill <= READY_MAX);
    assign accept        = bus.sym_valid && bus.sym_ready;
    assign out_free      = !bus.out_valid || bus.out_ready;
    assign load_ok       = code_load && (state != ST_FLUSH);

    always_comb begin
        state_n     = state;
        acc_n       = acc;
        fill_n      = fill;
        out_valid_n = bus.out_valid && !bus.out_ready;
        out_byte_n  = bus.out_byte;
        out_last_n  = (bus.out_valid && bus.out_ready) ? 1'b0 : bus.out_last;
        err_n       = load_ok ? 1'b0 : err_unknown;

        case (state)
            ST_IDLE: begin
                if (code_load) state_n = ST_RUN;
            end
            ST_RUN: begin
                // Keep the final full byte in the accumulator when the message ends,
                // so FLUSH can tag it with out_last instead of emitting it untagged.
                if (out_free && fill >= BYTE_BITS && !(accept && bus.sym_last)) begin
                    out_valid_n = 1'b1;
                    out_byte_n  = acc[ACC_W-1 -: 8];
                    out_last_n  = 1'b0;
                    acc_n       = acc << 8;
                    fill_n      = fill - BYTE_BITS;
                end
                if (accept) begin
                    if (!hit) err_n = 1'b1;
                    acc_n  = acc_n | ({{(ACC_W-MAX_CHAR_COUNT){1'b0}}, hit_value}
                                      << (FULL_W - fill_n - FILL_W'(hit_len)));
                    fill_n = fill_n + FILL_W'(hit_len);
                    if (bus.sym_last) state_n = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (bus.out_valid && bus.out_last) begin
                    if (bus.out_ready) state_n = ST_RUN;
                end else if (out_free) begin
                    // Unused accumulator bits are always zero, so padding comes for free.
                    out_valid_n = 1'b1;
                    out_byte_n  = acc[ACC_W-1 -: 8];
                    if (fill > BYTE_BITS) begin
                        out_last_n = 1'b0;
                        acc_n      = acc << 8;
                        fill_n     = fill - BYTE_BITS;
                    end else begin
                        out_last_n = 1'b1;
                        acc_n      = '0;
                        fill_n     = '0;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            acc           <= '0;
            fill          <= '0;
            bus.out_valid <= 1'b0;
            bus.out_byte  <= 8'h00;
            bus.out_last  <= 1'b0;
            err_unknown   <= 1'b0;
            tbl_char      <= '0;
            tbl_value     <= '0;
            tbl_mask      <= '0;
        end else begin
            state         <= state_n;
            acc           <= acc_n;
            fill          <= fill_n;
            bus.out_valid <= out_valid_n;
            bus.out_byte  <= out_byte_n;
            bus.out_last  <= out_last_n;
            err_unknown   <= err_n;
            if (load_ok) begin
                tbl_char  <= table_char;
                tbl_value <= table_value;
                tbl_mask  <= table_mask;
            end
        end
    end

endmodule

// File: tb/tb_huff_bit_packer.sv
// tb/tb_huff_bit_packer.sv - scoreboard bench for huff_bit_packer with directed messages
module tb_huff_bit_packer;

    logic clk = 1'b0;
    logic reset;
    logic code_load;
    logic [2:0][7:0] table_char;
    logic [2:0][2:0] table_value;
    logic [2:0][2:0] table_mask;
    logic err_unknown;

    huff_bit_packer_if bus();

    huff_bit_packer dut (
        .clk         (clk),
        .reset       (reset),
        .code_load   (code_load),
        .table_char  (table_char),
        .table_value (table_value),
        .table_mask  (table_mask),
        .bus         (bus.slave),
        .err_unknown (err_unknown)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [8:0] exp_q[$];

    logic       hold_pend = 1'b0;
    logic [8:0] hold_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks hold-under-backpressure.
    always @(negedge clk) begin
        logic [8:0] e;
        if (reset) begin
            hold_pend <= 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_data", 32'({bus.out_last, bus.out_byte}), 32'(hold_val));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_byte: got 0x%0h last=%0d, expected none",
                             bus.out_byte, bus.out_last);
                end else begin
                    e = exp_q.pop_front();
                    check("out_byte", 32'(bus.out_byte), 32'(e[7:0]));
                    check("out_last", 32'(bus.out_last), 32'(e[8]));
                end
            end
            hold_pend <= bus.out_valid && !bus.out_ready;
            hold_val  <= {bus.out_last, bus.out_byte};
        end
    end

    task automatic load_table();
        table_char  = {8'h63, 8'h62, 8'h61};
        table_value = {3'b011, 3'b010, 3'b000};
        table_mask  = {3'b011, 3'b011, 3'b001};
        code_load   = 1'b1;
        @(posedge clk); #1;
        code_load   = 1'b0;
    endtask

    task automatic send(input logic [7:0] c, input logic last);
        int n = 0;
        bus.sym_char  = c;
        bus.sym_last  = last;
        bus.sym_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.sym_ready) begin
                @(posedge clk); #1;
                break;
            end
            n++;
            if (n > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sym_timeout: got no sym_ready, expected acceptance of 0x%0h", c);
                break;
            end
        end
        bus.sym_valid = 1'b0;
        bus.sym_last  = 1'b0;
    endtask

    task automatic send_abcabc();
        logic [7:0] s [6];
        s = '{8'h61, 8'h62, 8'h63, 8'h61, 8'h62, 8'h63};
        for (int i = 0; i < 6; i++) send(s[i], i == 5);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        code_load     = 1'b0;
        table_char    = '0;
        table_value   = '0;
        table_mask    = '0;
        bus.sym_valid = 1'b0;
        bus.sym_char  = 8'h00;
        bus.sym_last  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_sym_ready", 32'(bus.sym_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_byte", 32'(bus.out_byte), 32'h00);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_err", 32'(err_unknown), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Symbols offered while IDLE are refused and leave no trace.
        bus.sym_char  = 8'h61;
        bus.sym_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("idle_sym_ready", 32'(bus.sym_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.sym_valid = 1'b0;
        check("idle_out_valid", 32'(bus.out_valid), 32'd0);
        check("idle_err", 32'(err_unknown), 32'd0);

        // a,b,c,a,b,c -> 0 10 11 0 10 11 -> 0x5A, 0xC0(last)
        load_table();
        exp_q.push_back({1'b0, 8'h5A});
        exp_q.push_back({1'b1, 8'hC0});
        send_abcabc();
        wait_drain();
        check("abc_err", 32'(err_unknown), 32'd0);

        // Eight single-bit zero codes fill exactly one byte: no padding byte.
        exp_q.push_back({1'b1, 8'h00});
        for (int i = 0; i < 8; i++) send(8'h61, i == 7);
        wait_drain();

        // Same message under 10 cycles of output backpressure.
        exp_q.push_back({1'b0, 8'h5A});
        exp_q.push_back({1'b1, 8'hC0});
        fork
            begin
                bus.out_ready = 1'b0;
                repeat (10) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
            send_abcabc();
        join
        wait_drain();

        // Unknown symbol mid-stream: 0 + 10 -> 0x40(last), sticky error.
        exp_q.push_back({1'b1, 8'h40});
        send(8'h61, 1'b0);
        send(8'h7A, 1'b0);
        send(8'h62, 1'b1);
        wait_drain();
        check("unk_err", 32'(err_unknown), 32'd1);
        exp_q.push_back({1'b0, 8'h5A});
        exp_q.push_back({1'b1, 8'hC0});
        send_abcabc();
        wait_drain();
        check("unk_err_sticky", 32'(err_unknown), 32'd1);
        load_table();
        check("unk_err_cleared", 32'(err_unknown), 32'd0);

        // Reset with a byte pending: everything buffered is discarded.
        bus.out_ready = 1'b0;
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        send(8'h63, 1'b0);
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("pend_out_valid", 32'(bus.out_valid), 32'd1);
        check("pend_out_byte", 32'(bus.out_byte), 32'h5A);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_sym_ready", 32'(bus.sym_ready), 32'd0);
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        load_table();
        exp_q.push_back({1'b0, 8'h5A});
        exp_q.push_back({1'b1, 8'hC0});
        send_abcabc();
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
